instruction_sequencer: RTL and testbench
========================================

Name: instruction_sequencer

Overview:
- Upstream feeder for control_circuit: stores a short program of 11-bit instructions and presents them one at a time on INSTRUCTION.
- Holds each instruction stable until control_circuit pulses Done, then fetches the next one.
- Includes a per-instruction watchdog that aborts the program if Done never arrives.
- Programmed from the test/host side while idle; started with a one-cycle start pulse.

Parameters:
- AW, 3, program memory address width (depth 2^AW = 8 instructions)
- TIMEOUT, 16, max cycles in EXEC without Done before ERROR (must be >= 2)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- prog_we  input  1  program memory write strobe (honoured only in IDLE/FINISH/ERROR)
- prog_addr  input  AW  program memory write address
- prog_data  input  11  instruction word to write
- prog_len  input  AW+1  number of instructions to run (0..2^AW), sampled on start
- start  input  1  one-cycle pulse; begins execution at address 0
- Done  input  1  completion pulse from control_circuit
- INSTRUCTION  output  11  instruction to control_circuit ({op[10:8], Rx[7:5], Ry/imm[4:0]})
- instr_valid  output  1  high while INSTRUCTION carries a live instruction (EXEC)
- pc  output  AW+1  index of the current/next instruction
- busy  output  1  high in FETCH or EXEC
- prog_done  output  1  one-cycle pulse when the last instruction's Done is seen
- timeout_err  output  1  high in ERROR (sticky)

Behaviour:
- Reset (async): state=IDLE; pc=0; INSTRUCTION=11'h000; instr_valid=0; busy=0; prog_done=0; timeout_err=0; watchdog=0. Memory contents are not cleared.
- Memory: 2^AW x 11, synchronous write on prog_we, registered read in FETCH. prog_we is ignored while busy.
- IDLE:
  - start with prog_len>0: latch len, pc<=0, go to FETCH.
  - start with prog_len=0: pulse prog_done next cycle, stay IDLE.
- FETCH (1 cycle): instr_reg<=mem[pc]; go to EXEC; watchdog<=0.
- EXEC: INSTRUCTION=instr_reg, instr_valid=1, held stable for the whole state. watchdog increments each cycle.
  - Done=1: pc<=pc+1. If pc+1==len, go to FINISH; otherwise go to FETCH.
  - No Done and watchdog==TIMEOUT-1: go to ERROR.
  - Done and timeout in the same cycle: Done wins.
- FINISH: prog_done=1 for exactly one cycle; go to IDLE. pc keeps the final count.
- ERROR: timeout_err=1, pc frozen. Leaves only on reset or on a start pulse, which clears timeout_err and behaves as IDLE start.
- Outside EXEC: INSTRUCTION=11'h000 (register field 000 selects no register) and instr_valid=0.
- Done outside EXEC is ignored.
- start while busy is ignored.
- Latency:
  - start to first instr_valid: 2 cycles.
  - Done to next instr_valid: 2 cycles (one low cycle between instructions).
- pc never wraps; at len=2^AW, pc reaches 2^AW, hence the AW+1 width.
- Reset mid-EXEC: instr_valid and INSTRUCTION drop asynchronously; the program must be restarted.

Test Plan:
- Load program 0x026 (load r1,6), 0x128 (mov r1,r2), 0x270 (add r3,r4), 0x350 (sub r2,r4); len=4; start; Done 3 cycles after each instr_valid rise -> INSTRUCTION shows each word in order, stable until Done; prog_done pulses once; pc=4; no timeout_err.
- Same program with Done held off for 16 cycles on the 2nd instruction (TIMEOUT=16) -> timeout_err=1, pc=1, INSTRUCTION=0x000; then start -> timeout_err clears and execution restarts at 0x026.
- Done asserted in the exact cycle watchdog==15 -> treated as completion; advances to 0x270; no error.
- prog_len=0, start -> prog_done pulse next cycle; instr_valid never rises; busy stays 0.
- prog_we to addr 0 with 0x3FF during EXEC -> ignored; re-run shows original 0x026. Extra start pulses while busy -> no effect on pc.
- Async reset asserted mid-EXEC on the 3rd instruction -> all outputs reach reset values without a clock edge; after reset, start with len=4 -> re-runs from 0x026 (memory retained).

Source files
------------

// File: rtl/instruction_sequencer.sv
// ---------------------------------------------------------------------------
// instruction_sequencer
//
// Upstream feeder for control_circuit. Holds a short program of 11-bit
// instructions and presents them one at a time on INSTRUCTION. Each word is
// held stable until control_circuit pulses Done, and then the next word is
// fetched. A per-instruction watchdog aborts the program if Done never
// arrives. The program memory is written from the host side while the
// sequencer is not busy, and a one-cycle start pulse runs the program.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   prog_we      program memory write strobe (ignored while busy)
//   prog_addr    program memory write address
//   prog_data    instruction word to write
//   prog_len     number of instructions to run (0..2^AW), sampled on start
//   start        one-cycle pulse, runs the program from address 0
//   Done         completion pulse from control_circuit
//   INSTRUCTION  {op[10:8], Rx[7:5], Ry/imm[4:0]}, all zero outside EXEC
//   instr_valid  high while INSTRUCTION carries a live instruction
//   pc           index of the current/next instruction (never wraps)
//   busy         high in FETCH or EXEC
//   prog_done    one-cycle pulse when the program completes
//   timeout_err  high while stopped by the watchdog (sticky until start)
// ---------------------------------------------------------------------------
module instruction_sequencer #(
  parameter int AW      = 3,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [10:0]   prog_data,
  input  logic [AW:0]   prog_len,
  input  logic          start,
  input  logic          Done,
  output logic [10:0]   INSTRUCTION,
  output logic          instr_valid,
  output logic [AW:0]   pc,
  output logic          busy,
  output logic          prog_done,
  output logic          timeout_err
);

  localparam int WW = $clog2(TIMEOUT);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_FINISH = 3'd3;
  localparam logic [2:0] S_ERROR  = 3'd4;

  localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT - 1);

  logic [2:0]    state_q, state_d;
  logic [AW:0]   pc_q, pc_d;
  logic [AW:0]   len_q, len_d;
  logic [10:0]   instr_q, instr_d;
  logic [WW-1:0] wdog_q, wdog_d;
  logic          zero_done_q, zero_done_d;
  logic [AW:0]   pc_inc;

  logic [10:0] mem [2**AW];

  // NOTE: the program store has no reset so it survives a reset and can be
  // mapped onto plain RAM; only the control registers below are reset.
  always_ff @(posedge clk) begin
    if (prog_we && !busy) mem[prog_addr] <= prog_data;
  end

  assign pc_inc = pc_q + {{AW{1'b0}}, 1'b1};

  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_d     = state_q;
    pc_d        = pc_q;
    len_d       = len_q;
    instr_d     = instr_q;
    wdog_d      = wdog_q;
    zero_done_d = 1'b0;

    case (state_q)
      S_IDLE, S_FINISH, S_ERROR: begin
        if (start) begin
          if (prog_len != '0) begin
            len_d   = prog_len;
            pc_d    = '0;
            state_d = S_FETCH;
          end else begin
            // Empty program: report completion at once, never go busy.
            zero_done_d = 1'b1;
            state_d     = S_IDLE;
          end
        end else if (state_q == S_FINISH) begin
          state_d = S_IDLE;
        end
      end

      S_FETCH: begin
        instr_d = mem[pc_q[AW-1:0]];
        wdog_d  = '0;
        state_d = S_EXEC;
      end

      S_EXEC: begin
        // Done takes priority over a watchdog expiry in the same cycle.
        if (Done) begin
          pc_d    = pc_inc;
          state_d = (pc_inc == len_q) ? S_FINISH : S_FETCH;
        end else if (wdog_q == WDOG_LAST) begin
          state_d = S_ERROR;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      len_q       <= '0;
      instr_q     <= '0;
      wdog_q      <= '0;
      zero_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      len_q       <= len_d;
      instr_q     <= instr_d;
      wdog_q      <= wdog_d;
      zero_done_q <= zero_done_d;
    end
  end

  // Outputs decode directly from state so a reset drops them immediately.
  assign instr_valid = (state_q == S_EXEC);
  assign INSTRUCTION = instr_valid ? instr_q : 11'h000;
  assign pc          = pc_q;
  assign busy        = (state_q == S_FETCH) || (state_q == S_EXEC);
  assign prog_done   = (state_q == S_FINISH) || zero_done_q;
  assign timeout_err = (state_q == S_ERROR);

endmodule

// File: tb/tb_instruction_sequencer.sv
// ---------------------------------------------------------------------------
// tb_instruction_sequencer
//
// Directed bench for instruction_sequencer: normal program run, watchdog
// abort and restart, Done on the last watchdog cycle, empty program,
// writes and starts while busy, and asynchronous reset mid-instruction.
// ---------------------------------------------------------------------------
module tb_instruction_sequencer;

  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [10:0]   prog_data;
  logic [AW:0]   prog_len;
  logic          start;
  logic          Done;
  logic [10:0]   INSTRUCTION;
  logic          instr_valid;
  logic [AW:0]   pc;
  logic          busy;
  logic          prog_done;
  logic          timeout_err;

  int total = 0;
  int bad   = 0;

  logic [10:0] prog [4] = '{11'h026, 11'h128, 11'h270, 11'h350};

  instruction_sequencer #(.AW(AW), .TIMEOUT(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .prog_len    (prog_len),
    .start       (start),
    .Done        (Done),
    .INSTRUCTION (INSTRUCTION),
    .instr_valid (instr_valid),
    .pc          (pc),
    .busy        (busy),
    .prog_done   (prog_done),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_instr"}, 32'(INSTRUCTION), 32'h000);
    check({tag, "_valid"}, 32'(instr_valid), 32'd0);
    check({tag, "_pc"},    32'(pc),          32'd0);
    check({tag, "_busy"},  32'(busy),        32'd0);
    check({tag, "_pdone"}, 32'(prog_done),   32'd0);
    check({tag, "_terr"},  32'(timeout_err), 32'd0);
  endtask

  // Entered just after the edge that put the sequencer into EXEC. Holds the
  // instruction for 'hold' cycles, pulsing Done in the last one.
  task automatic exec_one(input logic [10:0] w, input int idx, input int hold);
    check("exec_instr", 32'(INSTRUCTION), 32'(w));
    check("exec_valid", 32'(instr_valid), 32'd1);
    check("exec_pc",    32'(pc),          32'(idx));
    repeat (hold - 1) begin
      tick();
      check("exec_hold", 32'(INSTRUCTION), 32'(w));
    end
    Done = 1'b1;
    tick();
    Done = 1'b0;
  endtask

  // Issues start with the given length; returns just after the start edge.
  task automatic pulse_start(input logic [AW:0] len);
    prog_len = len;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  // Runs the four-word program from the start edge to the FINISH cycle.
  task automatic run_full();
    check("fetch_busy",  32'(busy),        32'd1);
    check("fetch_valid", 32'(instr_valid), 32'd0);
    tick();
    for (int k = 0; k < 4; k++) begin
      exec_one(prog[k], k, 3);
      if (k < 3) begin
        check("gap_valid", 32'(instr_valid), 32'd0);
        check("gap_instr", 32'(INSTRUCTION), 32'h000);
        tick();
      end
    end
    check("finish_pdone", 32'(prog_done),   32'd1);
    check("finish_pc",    32'(pc),          32'd4);
    check("finish_terr",  32'(timeout_err), 32'd0);
    tick();
    check("idle_pdone", 32'(prog_done), 32'd0);
    check("idle_busy",  32'(busy),      32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    prog_we   = 1'b0;
    prog_addr = '0;
    prog_data = '0;
    prog_len  = '0;
    start     = 1'b0;
    Done      = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");
    reset = 1'b0;
    tick();

    // Load the program.
    for (int i = 0; i < 4; i++) begin
      prog_we   = 1'b1;
      prog_addr = AW'(i);
      prog_data = prog[i];
      tick();
    end
    prog_we = 1'b0;

    // Normal run of four instructions.
    pulse_start(4'd4);
    run_full();

    // Watchdog: no Done on the second instruction.
    pulse_start(4'd4);
    tick();
    exec_one(prog[0], 0, 3);
    tick();
    check("wd_instr", 32'(INSTRUCTION), 32'h128);
    repeat (15) tick();
    check("wd_last_valid", 32'(instr_valid), 32'd1);
    tick();
    check("wd_terr",  32'(timeout_err), 32'd1);
    check("wd_pc",    32'(pc),          32'd1);
    check("wd_instr0", 32'(INSTRUCTION), 32'h000);
    check("wd_valid", 32'(instr_valid), 32'd0);
    tick();
    check("wd_sticky", 32'(timeout_err), 32'd1);

    // Restart from ERROR, then Done exactly on the last watchdog cycle.
    pulse_start(4'd4);
    check("rs_terr", 32'(timeout_err), 32'd0);
    check("rs_pc",   32'(pc),          32'd0);
    tick();
    exec_one(prog[0], 0, 3);
    tick();
    exec_one(prog[1], 1, 16);
    check("edge_terr", 32'(timeout_err), 32'd0);
    check("edge_pc",   32'(pc),          32'd2);
    tick();
    exec_one(prog[2], 2, 3);
    tick();
    exec_one(prog[3], 3, 3);
    check("edge_pdone", 32'(prog_done), 32'd1);
    tick();

    // Empty program.
    pulse_start(4'd0);
    check("zero_pdone", 32'(prog_done),   32'd1);
    check("zero_busy",  32'(busy),        32'd0);
    check("zero_valid", 32'(instr_valid), 32'd0);
    tick();
    check("zero_pdone_off", 32'(prog_done),   32'd0);
    check("zero_busy2",     32'(busy),        32'd0);
    check("zero_valid2",    32'(instr_valid), 32'd0);

    // Extra starts and a memory write while busy.
    pulse_start(4'd4);
    start = 1'b1;
    tick();
    check("busy_start_pc", 32'(pc), 32'd0);
    prog_we   = 1'b1;
    prog_addr = '0;
    prog_data = 11'h3FF;
    tick();
    prog_we = 1'b0;
    start   = 1'b0;
    check("busy_we_instr", 32'(INSTRUCTION), 32'h026);
    check("busy_start_pc2", 32'(pc), 32'd0);
    Done = 1'b1;
    tick();
    Done = 1'b0;
    check("busy_pc1", 32'(pc), 32'd1);
    tick();
    exec_one(prog[1], 1, 2);
    tick();
    check("pre_rst_instr", 32'(INSTRUCTION), 32'h270);

    // Asynchronous reset in the middle of the third instruction.
    #2 reset = 1'b1;
    #1;
    check_reset_outputs("async");
    tick();
    reset = 1'b0;
    tick();

    // Memory survives reset and kept its original word 0.
    pulse_start(4'd4);
    run_full();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
